// File: rtl/itof_pipe_if.sv
// rtl/itof_pipe_if.sv - operand/result handshake bundle for the int-to-float converter
interface itof_pipe_if #(
    parameter int TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_data;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_data;
    logic [TAG_W-1:0] out_tag;

    modport slave (
        input  in_valid, in_data, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag
    );

    modport master (
        output in_valid, in_data, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag
    );
endinterface

// File: rtl/itof_pipe.sv
// rtl/itof_pipe.sv - three-stage signed int32 to single-precision converter, round-to-nearest-even
module itof_pipe #(
    parameter int TAG_W = 5
) (
    input  logic        clk,
    input  logic        rstn,
    itof_pipe_if.slave  bus
);
    logic             r_rdy;

    logic             r1_v;
    logic             r1_sign;
    logic [31:0]      r1_mag;
    logic             r1_zero;
    logic [TAG_W-1:0] r1_tag;

    logic             r2_v;
    logic             r2_sign;
    logic [31:0]      r2_norm;
    logic [4:0]       r2_lz;
    logic             r2_zero;
    logic [TAG_W-1:0] r2_tag;

    logic             r3_v;
    logic [31:0]      r3_data;
    logic [TAG_W-1:0] r3_tag;

    logic             w_adv;
    logic             w_in_fire;
    logic [31:0]      w_mag;
    logic [4:0]       w_lz;
    logic [31:0]      w_norm;
    logic [22:0]      w_man;
    logic             w_round_up;
    logic             w_carry;
    logic [22:0]      w_man_r;
    logic [7:0]       w_exp;
    logic [31:0]      w_res;

    // Whole pipe moves together; only a held result at the output can stall it.
    assign w_adv     = !(r3_v && !bus.out_ready);
    assign w_in_fire = bus.in_valid && bus.in_ready;

    assign bus.in_ready  = w_adv && r_rdy;
    assign bus.out_valid = r3_v;
    assign bus.out_data  = r3_data;
    assign bus.out_tag   = r3_tag;

    // Two's-complement negate leaves 0x80000000 unchanged, which is the correct unsigned magnitude.
    assign w_mag = bus.in_data[31] ? (~bus.in_data + 32'd1) : bus.in_data;

    always_comb begin
        w_lz = 5'd0;
        for (int i = 0; i < 32; i++) begin
            if (r1_mag[i]) begin
                w_lz = 5'(31 - i);
            end
        end
    end

    assign w_norm = r1_mag << w_lz;

    assign w_man      = r2_norm[30:8];
    assign w_round_up = r2_norm[7] && ((|r2_norm[6:0]) || r2_norm[8]);
    assign {w_carry, w_man_r} = {1'b0, w_man} + {23'd0, w_round_up};
    assign w_exp = 8'd158 - {3'd0, r2_lz} + {7'd0, w_carry};
    assign w_res = r2_zero ? 32'd0 : {r2_sign, w_exp, w_man_r};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rdy   <= 1'b0;
            r1_v    <= 1'b0;
            r1_sign <= 1'b0;
            r1_mag  <= '0;
            r1_zero <= 1'b0;
            r1_tag  <= '0;
            r2_v    <= 1'b0;
            r2_sign <= 1'b0;
            r2_norm <= '0;
            r2_lz   <= '0;
            r2_zero <= 1'b0;
            r2_tag  <= '0;
            r3_v    <= 1'b0;
            r3_data <= '0;
            r3_tag  <= '0;
        end else begin
            r_rdy <= 1'b1;
            if (w_adv) begin
                r1_v    <= w_in_fire;
                r1_sign <= bus.in_data[31];
                r1_mag  <= w_mag;
                r1_zero <= (bus.in_data == 32'd0);
                r1_tag  <= bus.in_tag;

                r2_v    <= r1_v;
                r2_sign <= r1_sign;
                r2_norm <= w_norm;
                r2_lz   <= w_lz;
                r2_zero <= r1_zero;
                r2_tag  <= r1_tag;

                r3_v    <= r2_v;
                r3_data <= w_res;
                r3_tag  <= r2_tag;
            end
        end
    end
endmodule

// File: tb/tb_itof_pipe.sv
// tb/tb_itof_pipe.sv - scoreboard bench for itof_pipe
module tb_itof_pipe;
    localparam int TAG_W = 5;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    itof_pipe_if #(.TAG_W(TAG_W)) ifc();
    itof_pipe #(.TAG_W(TAG_W)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (ifc.slave)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit rand_mode = 1'b0;

    logic [31:0]      exp_d[$];
    logic [TAG_W-1:0] exp_t[$];
    int               out_cyc[$];

    logic [31:0]      chk_d;
    logic [TAG_W-1:0] chk_t;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Host double path: int->real is exact, then round 52-bit fraction to 23 bits.
    function automatic logic [31:0] ref_cvt(input logic [31:0] v);
        real         r;
        logic [63:0] b;
        logic [23:0] m;
        logic [7:0]  ef;
        if (v == 32'd0) return 32'd0;
        r  = $itor($signed(v));
        b  = $realtobits(r);
        m  = {1'b0, b[51:29]};
        ef = 8'(b[62:52] - 11'd896);
        if (b[28] && ((|b[27:0]) || b[29])) m = m + 24'd1;
        if (m[23]) ef = ef + 8'd1;
        return {b[63], ef, m[22:0]};
    endfunction

    always @(negedge clk) begin
        if (rstn && ifc.out_valid && ifc.out_ready) begin
            chk("out_expected", {31'd0, exp_d.size() != 0}, 32'd1);
            if (exp_d.size() != 0) begin
                chk_d = exp_d.pop_front();
                chk_t = exp_t.pop_front();
                out_cyc.push_back(cyc);
                chk("out_data", ifc.out_data, chk_d);
                chk("out_tag", {27'd0, ifc.out_tag}, {27'd0, chk_t});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_mode) ifc.out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send(input logic [31:0] d, input logic [TAG_W-1:0] t, input logic [31:0] e);
        bit acc;
        int n;
        ifc.in_valid = 1'b1;
        ifc.in_data  = d;
        ifc.in_tag   = t;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 500) begin
            @(negedge clk);
            acc = ifc.in_ready;
            tick();
            n++;
        end
        ifc.in_valid = 1'b0;
        if (acc) begin
            exp_d.push_back(e);
            exp_t.push_back(t);
        end else begin
            chk("send_timeout", 32'd0, 32'd1);
        end
    endtask

    task automatic single(input logic [31:0] d, input logic [TAG_W-1:0] t, input logic [31:0] e);
        send(d, t, e);
        @(negedge clk);
        chk("lat_c1", {31'd0, ifc.out_valid}, 32'd0);
        @(negedge clk);
        chk("lat_c2", {31'd0, ifc.out_valid}, 32'd0);
        @(negedge clk);
        chk("lat_c3", {31'd0, ifc.out_valid}, 32'd1);
        tick();
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_d.size() != 0 && n < 2000) begin
            tick();
            n++;
        end
        chk("drain_empty", exp_d.size(), 32'd0);
        repeat (2) tick();
    endtask

    logic [31:0] st_val[5] = '{32'd2, 32'd3, 32'hFFFFFFF9, 32'd100, 32'd1000};
    logic [31:0] st_exp[5] = '{32'h40000000, 32'h40400000, 32'hC0E00000, 32'h42C80000, 32'h447A0000};
    logic [31:0] sm_val[8] = '{32'd0, 32'd1, 32'hFFFFFFFF, 32'h80000000,
                               32'h7FFFFFFF, 32'd16777217, 32'd16777219, 32'd16777221};
    logic [31:0] sm_exp[8] = '{32'h00000000, 32'h3F800000, 32'hBF800000, 32'hCF000000,
                               32'h4F000000, 32'h4B800000, 32'h4B800002, 32'h4B800002};

    initial begin
        logic [31:0]      hd;
        logic [TAG_W-1:0] ht;
        logic [31:0]      d;
        bit               have;
        bit               ir;
        int               idx;

        ifc.in_valid  = 1'b0;
        ifc.in_data   = '0;
        ifc.in_tag    = '0;
        ifc.out_ready = 1'b1;

        // Reset state and in_ready release timing
        @(negedge clk);
        chk("rst_out_valid", {31'd0, ifc.out_valid}, 32'd0);
        chk("rst_out_data", ifc.out_data, 32'd0);
        chk("rst_out_tag", {27'd0, ifc.out_tag}, 32'd0);
        chk("rst_in_ready", {31'd0, ifc.in_ready}, 32'd0);
        @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        chk("rel_in_ready_lo", {31'd0, ifc.in_ready}, 32'd0);
        @(negedge clk);
        chk("rel_in_ready_hi", {31'd0, ifc.in_ready}, 32'd1);
        tick();

        // Single ops with latency checks, including tie rounding
        for (int i = 0; i < 8; i++) single(sm_val[i], TAG_W'(i + 16), sm_exp[i]);
        drain();

        // Back-to-back stream of 8
        out_cyc.delete();
        for (int i = 0; i < 8; i++) send(sm_val[i], TAG_W'(i), sm_exp[i]);
        drain();
        chk("stream_count", out_cyc.size(), 32'd8);
        if (out_cyc.size() == 8) chk("stream_contig", 32'(out_cyc[7] - out_cyc[0]), 32'd7);

        // Stall with out_ready low: fill, hold stable, then drain in order
        ifc.out_ready = 1'b0;
        idx  = 0;
        have = 1'b0;
        ifc.in_valid = 1'b1;
        ifc.in_data  = st_val[0];
        ifc.in_tag   = TAG_W'(10);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            ir = ifc.in_ready;
            if (ifc.out_valid) begin
                if (!have) begin
                    hd = ifc.out_data;
                    ht = ifc.out_tag;
                    have = 1'b1;
                end else begin
                    chk("hold_data", ifc.out_data, hd);
                    chk("hold_tag", {27'd0, ifc.out_tag}, {27'd0, ht});
                end
            end
            tick();
            if (ir && ifc.in_valid) begin
                exp_d.push_back(st_exp[idx]);
                exp_t.push_back(TAG_W'(10 + idx));
                idx++;
                ifc.in_data = st_val[idx % 5];
                ifc.in_tag  = TAG_W'(10 + idx);
            end
        end
        @(negedge clk);
        chk("stall_accepted", idx, 32'd3);
        chk("stall_in_ready", {31'd0, ifc.in_ready}, 32'd0);
        chk("stall_out_valid", {31'd0, ifc.out_valid}, 32'd1);
        tick();
        ifc.out_ready = 1'b1;
        for (int i = 3; i < 5; i++) send(st_val[i], TAG_W'(10 + i), st_exp[i]);
        drain();
        chk("stall_idle", {31'd0, ifc.out_valid}, 32'd0);

        // Asynchronous reset with operations in flight
        send(32'd7, TAG_W'(1), 32'h40E00000);
        send(32'd8, TAG_W'(2), 32'h41000000);
        send(32'd9, TAG_W'(3), 32'h41100000);
        #1 rstn = 1'b0;
        #1;
        chk("arst_out_valid", {31'd0, ifc.out_valid}, 32'd0);
        chk("arst_out_data", ifc.out_data, 32'd0);
        chk("arst_in_ready", {31'd0, ifc.in_ready}, 32'd0);
        exp_d.delete();
        exp_t.delete();
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 rstn = 1'b1;
        single(32'd5, TAG_W'(21), 32'h40A00000);
        drain();

        // Random sweep with random bubbles and back-pressure
        rand_mode = 1'b1;
        for (int n = 0; n < 20000; n++) begin
            case ($urandom_range(0, 3))
                0: d = $urandom;
                1: d = 32'($urandom_range(0, 1000));
                2: d = (32'd1 << $urandom_range(0, 30)) + 32'($urandom_range(0, 3));
                default: d = -((32'd1 << $urandom_range(0, 30)) + 32'($urandom_range(0, 255)));
            endcase
            if ($urandom_range(0, 3) == 0) tick();
            send(d, TAG_W'(n), ref_cvt(d));
        end
        rand_mode = 1'b0;
        ifc.out_ready = 1'b1;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
